// File: rtl/chip_pkg.sv
// Shared chip-level constants: button channel count and the bit position of
// each front-panel button on io_in / btn_raw.
package chip_pkg;

  localparam int unsigned NUM_BTN = 5;

  // Channel indices, matching io_in bit positions
  localparam int unsigned BTN_CONFIRM     = 0;
  localparam int unsigned BTN_CLEAR       = 1;
  localparam int unsigned BTN_ALGO_SELECT = 2;
  localparam int unsigned BTN_ENTER0      = 3;
  localparam int unsigned BTN_ENTER1      = 4;

  // Default number of consecutive agreeing samples needed to accept a change
  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 16;

endpackage : chip_pkg

// File: rtl/debounce_channel.sv
// One button channel: two-flop synchronizer, saturating agreement counter,
// debounced level register and a registered rising-edge strobe.
module debounce_channel #(
  parameter int unsigned DebounceCycles = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic raw_i,
  output logic level_o,
  output logic pulse_o
);

  localparam int unsigned    CntW   = $clog2(DebounceCycles);
  localparam logic [CntW-1:0] CntMax = CntW'(DebounceCycles - 1);

  logic            sync0_q, sync1_q;
  logic            stable_q, stable_d;
  logic            pulse_q, pulse_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  // Synchronize the asynchronous raw level into the clock domain
  always_ff @(posedge clock) begin
    if (reset) begin
      sync0_q <= 1'b0;
      sync1_q <= 1'b0;
    end else begin
      sync0_q <= raw_i;
      sync1_q <= sync0_q;
    end
  end

  // Count consecutive mismatching samples; commit on the last one. The strobe is
  // computed alongside the commit so it lines up with the first high level cycle.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    pulse_d  = 1'b0;
    if (sync1_q != stable_q) begin
      if (cnt_q == CntMax) begin
        stable_d = sync1_q;
        pulse_d  = sync1_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Debounce state registers
  always_ff @(posedge clock) begin
    if (reset) begin
      stable_q <= 1'b0;
      cnt_q    <= '0;
      pulse_q  <= 1'b0;
    end else begin
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      pulse_q  <= pulse_d;
    end
  end

  assign level_o = stable_q;
  assign pulse_o = pulse_q;

endmodule : debounce_channel

// File: rtl/button_conditioner.sv
// Front-panel button conditioner: NUM_BTN independent debounce channels.
// btn_pulse feeds the confirm/clear/enter strobes directly and
// btn_level[BTN_ALGO_SELECT] serves as the mode level downstream.
module button_conditioner #(
  parameter int unsigned NUM_BTN         = chip_pkg::NUM_BTN,
  parameter int unsigned DEBOUNCE_CYCLES = chip_pkg::DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_pulse
);

  // A single-sample window would defeat debouncing and give a zero-width counter
  if (DEBOUNCE_CYCLES < 2) begin : g_bad_param
    $error("button_conditioner: DEBOUNCE_CYCLES must be >= 2");
  end

  // One fully independent channel per button
  for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
    debounce_channel #(
      .DebounceCycles(DEBOUNCE_CYCLES)
    ) u_chan (
      .clock  (clock),
      .reset  (reset),
      .raw_i  (btn_raw[i]),
      .level_o(btn_level[i]),
      .pulse_o(btn_pulse[i])
    );
  end

endmodule : button_conditioner

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DEBOUNCE_CYCLES=4: a level change
// first sampled on edge E must appear on btn_level right after edge E+5.
module tb_button_conditioner;
  import chip_pkg::*;

  localparam int unsigned NB = 5;

  logic          clock = 1'b0;
  logic          reset;
  logic [NB-1:0] btn_raw;
  logic [NB-1:0] btn_level;
  logic [NB-1:0] btn_pulse;

  int errors = 0;
  int checks = 0;
  int n;
  logic [NB-1:0] seen;

  button_conditioner #(
    .NUM_BTN        (NB),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .btn_raw  (btn_raw),
    .btn_level(btn_level),
    .btn_pulse(btn_pulse)
  );

  always #5 clock = ~clock;

  // Advance one rising edge and settle past it before sampling/driving
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [NB-1:0] obs, input logic [NB-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset, including raw inputs high while reset is held
    reset   = 1'b1;
    btn_raw = '0;
    tick();
    tick();
    check("reset_level", btn_level, 5'b00000);
    check("reset_pulse", btn_pulse, 5'b00000);
    btn_raw = '1;
    repeat (3) tick();
    check("reset_hold_level", btn_level, 5'b00000);
    check("reset_hold_pulse", btn_pulse, 5'b00000);
    btn_raw = '0;
    repeat (2) tick();
    reset = 1'b0;
    repeat (3) tick();
    check("idle_level", btn_level, 5'b00000);

    // Clean press on confirm: level after edge 5, one-cycle pulse
    btn_raw[BTN_CONFIRM] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("press_wait_level", btn_level, 5'b00000);
    end
    tick();
    check("press_level", btn_level, 5'b00001);
    check("press_pulse", btn_pulse, 5'b00001);
    tick();
    check("press_pulse_once", btn_pulse, 5'b00000);
    repeat (14) tick();
    check("press_held_level", btn_level, 5'b00001);

    // Release confirm: level falls, no pulse
    btn_raw[BTN_CONFIRM] = 1'b0;
    n = 0;
    repeat (5) begin
      tick();
      n += int'(btn_pulse[BTN_CONFIRM]);
    end
    check("rel0_still_high", btn_level, 5'b00001);
    tick();
    n += int'(btn_pulse[BTN_CONFIRM]);
    check("rel0_level", btn_level, 5'b00000);
    check_int("rel0_no_pulse", n, 0);

    // Glitch on clear: 3 high samples must be rejected
    seen = '0;
    btn_raw[BTN_CLEAR] = 1'b1;
    repeat (3) begin
      tick();
      seen |= btn_level | btn_pulse;
    end
    btn_raw[BTN_CLEAR] = 1'b0;
    repeat (10) begin
      tick();
      seen |= btn_level | btn_pulse;
    end
    check("glitch_quiet", seen, 5'b00000);

    // Bounce on enter0: 2-cycle toggles, then held high
    n    = 0;
    seen = '0;
    repeat (4) begin
      btn_raw[BTN_ENTER0] = 1'b1;
      repeat (2) begin
        tick();
        n += int'(btn_pulse[BTN_ENTER0]);
        seen |= btn_level;
      end
      btn_raw[BTN_ENTER0] = 1'b0;
      repeat (2) begin
        tick();
        n += int'(btn_pulse[BTN_ENTER0]);
        seen |= btn_level;
      end
    end
    btn_raw[BTN_ENTER0] = 1'b1;
    repeat (5) begin
      tick();
      n += int'(btn_pulse[BTN_ENTER0]);
      seen |= btn_level;
    end
    check("bounce_no_early_level", seen, 5'b00000);
    tick();
    n += int'(btn_pulse[BTN_ENTER0]);
    check("bounce_level", btn_level, 5'b01000);
    repeat (4) begin
      tick();
      n += int'(btn_pulse[BTN_ENTER0]);
    end
    check_int("bounce_one_pulse", n, 1);

    // Release on enter1: press first, then release without pulse
    btn_raw[BTN_ENTER1] = 1'b1;
    repeat (6) tick();
    check("rel4_pressed", btn_level, 5'b11000);
    tick();
    btn_raw[BTN_ENTER1] = 1'b0;
    n = 0;
    repeat (5) begin
      tick();
      n += int'(btn_pulse[BTN_ENTER1]);
    end
    check("rel4_still_high", btn_level, 5'b11000);
    tick();
    n += int'(btn_pulse[BTN_ENTER1]);
    check("rel4_level", btn_level, 5'b01000);
    repeat (3) begin
      tick();
      n += int'(btn_pulse[BTN_ENTER1]);
    end
    check_int("rel4_no_pulse", n, 0);

    // Simultaneous press on confirm and algo-select
    btn_raw[BTN_CONFIRM]     = 1'b1;
    btn_raw[BTN_ALGO_SELECT] = 1'b1;
    seen = '0;
    repeat (5) begin
      tick();
      seen |= btn_pulse;
    end
    check("simul_no_early_pulse", seen, 5'b00000);
    tick();
    check("simul_pulse", btn_pulse, 5'b00101);
    check("simul_level", btn_level, 5'b01101);
    tick();
    check("simul_pulse_once", btn_pulse, 5'b00000);

    // Reset after 3 mismatched samples on confirm, raw held high
    btn_raw = '0;
    repeat (8) tick();
    check("pre_rst_idle", btn_level, 5'b00000);
    btn_raw[BTN_CONFIRM] = 1'b1;
    repeat (5) tick();
    reset = 1'b1;
    tick();
    check("midrst_level", btn_level, 5'b00000);
    check("midrst_pulse", btn_pulse, 5'b00000);
    repeat (2) tick();
    check("midrst_hold", btn_level | btn_pulse, 5'b00000);
    reset = 1'b0;
    seen  = '0;
    repeat (5) begin
      tick();
      seen |= btn_level | btn_pulse;
    end
    check("postrst_wait", seen, 5'b00000);
    tick();
    check("postrst_level", btn_level, 5'b00001);
    check("postrst_pulse", btn_pulse, 5'b00001);
    tick();
    check("postrst_pulse_once", btn_pulse, 5'b00000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_button_conditioner
